rotate_kick_checker: RTL and testbench
======================================

// Module: rotate_kick_checker
// PURPOSE
//  Validates a rotation request for the falling 4x4 block before it is committed.
//  Drives the current float and direction into the combinational Rotate stage and
//  captures the rotated mask. Scans the board one row at a time against that mask,
//  trying horizontal wall-kick offsets in order. Returns the accepted mask and column,
//  or reports rejection so the game FSM keeps the old float.
// PARAMETERS
//  BOARD_W  10  board width in columns
//  BOARD_H  20  board height in rows (row 0 = top)
//  ROW_AW   5   width of row_addr, >= clog2(BOARD_H)
// PORTS
//  clk        in   1        system clock
//  rst        in   1        synchronous, active-high reset
//  req        in   1        rotate request, sampled only when busy=0
//  direction  in   1        0 = clockwise, 1 = counter-clockwise
//  float      in   [0:15]   current mask, bit 4*r+c = row r, col c
//  pos_x      in   5 (s)    board column of mask col 0, range -3..BOARD_W-1
//  pos_y      in   6 (s)    board row of mask row 0, range -4..BOARD_H-1
//  rot_src    out  [0:15]   mask presented to the Rotate stage
//  rot_dir    out  1        direction presented to the Rotate stage
//  rot_result in   [0:15]   combinational output of the Rotate stage
//  row_addr   out  ROW_AW   board row read address
//  row_data   in   [0:BOARD_W-1]  board row, bit j = column j; valid 1 cycle after row_addr
//  busy       out  1        high from the cycle after req is accepted until done
//  done       out  1        one-cycle completion pulse
//  ok         out  1        rotation accepted; valid while done=1, held until next done
//  new_float  out  [0:15]   accepted mask, or the original float if rejected
//  new_x      out  5 (s)    accepted column, or pos_x if rejected
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE. rst mid-operation aborts without a done pulse.
//  - States: IDLE -> ROT -> CHK -> DONE -> IDLE.
//  - IDLE: on req=1, latch float, direction, pos_x and pos_y; go to ROT. Cycle 0 is the req cycle.
//  - ROT (cycle 1): rot_src/rot_dir = latched values; latch rot_result as cand.
//  - CHK: kick sequence off = 0, +1, -1, +2, -2 (index k = 0..4).
//    - Each kick takes exactly 5 cycles. Row address r = 0..3 is issued in cycles 0..3.
//    - Row r is compared in the cycle after its address is issued. There is no early abort.
//  - Collision for mask bit (r, c) = 1, with X = pos_x + off + c and Y = pos_y + r:
//    - X < 0 or X >= BOARD_W: collision.
//    - Y >= BOARD_H: collision.
//    - Y < 0: no collision (spawn headroom).
//    - Otherwise: collision when row_data[X] = 1.
//  - For rows with Y outside 0..BOARD_H-1, row_addr = 0 and row_data is ignored.
//  - Arithmetic: all position arithmetic is signed, 7 bits internal. new_x = pos_x + off, truncated to 5 bits.
//  - First kick with no collision: DONE with ok=1, new_float = cand, new_x = pos_x + off.
//  - All kicks collide: ok=0, new_float = latched float, new_x = pos_x.
//  - Latency: done is in cycle 7 + 5k for success at kick k. Full rejection gives done in cycle 27.
//  - An all-zero cand always succeeds at k=0.
//  - req while busy=1 is ignored, with no queueing. req on the done cycle is ignored.
//  - busy is 1 in cycles 1..(done cycle - 1) and is 0 on the done cycle.
//  - rot_src and rot_dir hold their values until the next accepted req.
// CONFIGURATION
//  ROTATE_WALL_KICK_EN
//  - Defined: the 5-offset sequence above is used.
//  - Undefined: only off = 0 is tried. Done is in cycle 7 in every case, and the kick-sequencing logic is removed.
// TESTING
//  1. Empty board, T mask 0x4E00, x=3, y=0, req cw
//     -> done cycle 7, ok=1, new_float = rot_result, new_x = 3.
//  2. Empty board, vertical I in col 2 (0x2222), x=-2, y=5, cw
//     -> offsets 0, +1, -1 collide with the wall; ok=1 at k=3 in cycle 22, new_x = 0.
//  3. All board rows full, x=3, y=8
//     -> ok=0 in cycle 27, new_float = float, new_x = 3.
//  4. Scenario 2 with ROTATE_WALL_KICK_EN undefined
//     -> ok=0 in cycle 7, new_x = -2.
//  5. Floor check: y=18, rotated mask occupies mask row 2 (board row 20)
//     -> every kick collides, ok=0.
//  6. Protocol: req pulsed again in cycle 3 -> ignored, single done. Separate run: rst in cycle 4
//     -> busy=0 and all outputs 0 from cycle 5, no done.

Source files
------------

// File: rtl/rotate_kick_if.sv
// rotate_kick_if: request/response bundle between the game FSM (master) and
// the rotation checker (slave). The requester drives the float, direction and
// position with req. The checker returns busy/done/ok and the accepted mask and column.
interface rotate_kick_if;
   logic              req;
   logic              direction;
   logic [0:15]       float;
   logic signed [4:0] pos_x;
   logic signed [5:0] pos_y;
   logic              busy;
   logic              done;
   logic              ok;
   logic [0:15]       new_float;
   logic signed [4:0] new_x;

   modport master (
      output req, direction, float, pos_x, pos_y,
      input  busy, done, ok, new_float, new_x
   );

   modport slave (
      input  req, direction, float, pos_x, pos_y,
      output busy, done, ok, new_float, new_x
   );
endinterface

// File: rtl/rotate_kick_checker.sv
// rotate_kick_checker: validates a rotation of the falling 4x4 block.
// The latched float goes to the external Rotate stage and the rotated mask is
// captured as the candidate. The board is then scanned row by row for each
// horizontal kick offset. The first collision-free offset wins. If every offset
// collides, the original float and column are returned with ok=0.
// Optional feature macro: ROTATE_WALL_KICK_EN. When it is defined, the offsets
// 0,+1,-1,+2,-2 are tried. When it is undefined, only offset 0 is tried.
module rotate_kick_checker #(
   parameter int BOARD_W = 10,
   parameter int BOARD_H = 20,
   parameter int ROW_AW  = 5
) (
   input  logic               clk,
   input  logic               rst,
   rotate_kick_if.slave       bus,
   output logic [0:15]        rot_src,
   output logic               rot_dir,
   input  logic [0:15]        rot_result,
   output logic [ROW_AW-1:0]  row_addr,
   input  logic [0:BOARD_W-1] row_data
);

   typedef enum logic [1:0] {S_IDLE, S_ROT, S_CHK, S_DONE} state_t;

   // Board limits in the 7-bit signed position domain
   localparam logic signed [6:0] BW_S = 7'(BOARD_W);
   localparam logic signed [6:0] BH_S = 7'(BOARD_H);

   state_t            state_q, state_d;
   logic [0:15]       src_q, src_d;
   logic              dir_q, dir_d;
   logic signed [6:0] px_q, px_d;
   logic signed [6:0] py_q, py_d;
   logic [0:15]       cand_q, cand_d;
   logic [2:0]        cyc_q, cyc_d;
   logic              hit_q, hit_d;
   logic              ok_q, ok_d;
   logic [0:15]       nf_q, nf_d;
   logic signed [4:0] nx_q, nx_d;
`ifdef ROTATE_WALL_KICK_EN
   logic [2:0]        kick_q, kick_d;
`endif

   logic signed [6:0] off;
   logic signed [6:0] x_base;
   logic signed [6:0] addr_y;
   logic signed [6:0] cmp_y;
   logic [1:0]        cmp_idx;
   logic [0:3]        cmp_row;
   logic              row_hit;
   logic              last_kick;

`ifdef ROTATE_WALL_KICK_EN
   // Kick index to horizontal offset: 0, +1, -1, +2, -2
   function automatic logic signed [6:0] kick_offset(input logic [2:0] k);
      case (k)
         3'd1:    kick_offset = 7'sd1;
         3'd2:    kick_offset = -7'sd1;
         3'd3:    kick_offset = 7'sd2;
         3'd4:    kick_offset = -7'sd2;
         default: kick_offset = 7'sd0;
      endcase
   endfunction
`endif

   // One mask row against one board row. Side walls always collide and the
   // floor always collides. Rows above the top are free headroom.
   function automatic logic row_collides(input logic [0:3]        mrow,
                                         input logic signed [6:0] xb,
                                         input logic signed [6:0] y,
                                         input logic [0:BOARD_W-1] data);
      logic              hit;
      logic signed [6:0] x;
      hit = 1'b0;
      for (int c = 0; c < 4; c++) begin
         x = xb + 7'(c);
         if (mrow[c]) begin
            if (x < 7'sd0 || x >= BW_S) begin
               hit = 1'b1;
            end else if (y >= BH_S) begin
               hit = 1'b1;
            end else if (y >= 7'sd0) begin
               for (int j = 0; j < BOARD_W; j++) begin
                  if (x == 7'(j) && data[j]) hit = 1'b1;
               end
            end
         end
      end
      return hit;
   endfunction

   // Board read address: mask row r is requested in kick cycle r (0..3). Rows off the board read row 0.
   always_comb begin
      addr_y   = py_q + 7'(cyc_q[1:0]);
      row_addr = '0;
      if (state_q == S_CHK && cyc_q <= 3'd3 && addr_y >= 7'sd0 && addr_y < BH_S) begin
         row_addr = ROW_AW'(addr_y);
      end
   end

   // Collision test for the row whose data arrives this cycle (mask row cyc-1)
   always_comb begin
`ifdef ROTATE_WALL_KICK_EN
      off       = kick_offset(kick_q);
      last_kick = (kick_q == 3'd4);
`else
      off       = 7'sd0;
      last_kick = 1'b1;
`endif
      cmp_idx = cyc_q[1:0] - 2'd1;
      cmp_row = cand_q[{cmp_idx, 2'b00} +: 4];
      cmp_y   = py_q + 7'(cmp_idx);
      x_base  = px_q + off;
      row_hit = row_collides(cmp_row, x_base, cmp_y, row_data);
   end

   // Next-state and result selection for IDLE -> ROT -> CHK -> DONE
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dir_d   = dir_q;
      px_d    = px_q;
      py_d    = py_q;
      cand_d  = cand_q;
      cyc_d   = cyc_q;
      hit_d   = hit_q;
      ok_d    = ok_q;
      nf_d    = nf_q;
      nx_d    = nx_q;
`ifdef ROTATE_WALL_KICK_EN
      kick_d  = kick_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.req) begin
               state_d = S_ROT;
               src_d   = bus.float;
               dir_d   = bus.direction;
               px_d    = 7'(bus.pos_x);
               py_d    = 7'(bus.pos_y);
            end
         end
         S_ROT: begin
            cand_d  = rot_result;
            cyc_d   = 3'd0;
            hit_d   = 1'b0;
`ifdef ROTATE_WALL_KICK_EN
            kick_d  = 3'd0;
`endif
            state_d = S_CHK;
         end
         S_CHK: begin
            if (cyc_q == 3'd4) begin
               cyc_d = 3'd0;
               hit_d = 1'b0;
               if (!(hit_q || row_hit)) begin
                  state_d = S_DONE;
                  ok_d    = 1'b1;
                  nf_d    = cand_q;
                  nx_d    = 5'(x_base);
               end else if (last_kick) begin
                  state_d = S_DONE;
                  ok_d    = 1'b0;
                  nf_d    = src_q;
                  nx_d    = 5'(px_q);
               end else begin
`ifdef ROTATE_WALL_KICK_EN
                  kick_d  = kick_q + 3'd1;
`endif
               end
            end else begin
               cyc_d = cyc_q + 3'd1;
               // Cycle 0 only issues an address, so accumulation starts at cycle 1
               hit_d = (cyc_q == 3'd0) ? 1'b0 : (hit_q || row_hit);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control and visible result registers. Reset clears them and aborts any check in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         dir_q   <= 1'b0;
         cyc_q   <= '0;
         hit_q   <= 1'b0;
         ok_q    <= 1'b0;
         nf_q    <= '0;
         nx_q    <= '0;
`ifdef ROTATE_WALL_KICK_EN
         kick_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dir_q   <= dir_d;
         cyc_q   <= cyc_d;
         hit_q   <= hit_d;
         ok_q    <= ok_d;
         nf_q    <= nf_d;
         nx_q    <= nx_d;
`ifdef ROTATE_WALL_KICK_EN
         kick_q  <= kick_d;
`endif
      end
   end

   // Internal position and candidate registers. They are only read after being loaded.
   always_ff @(posedge clk) begin
      px_q   <= px_d;
      py_q   <= py_d;
      cand_q <= cand_d;
   end

   assign rot_src       = src_q;
   assign rot_dir       = dir_q;
   assign bus.busy      = (state_q == S_ROT) || (state_q == S_CHK);
   assign bus.done      = (state_q == S_DONE);
   assign bus.ok        = ok_q;
   assign bus.new_float = nf_q;
   assign bus.new_x     = nx_q;

endmodule

// File: tb/tb_rotate_kick_checker.sv
// tb_rotate_kick_checker: table of directed rotation cases, two protocol
// sequences (re-request while busy, reset mid-check), and randomized
// boards/masks scored against a cell-by-cell reference model.
module tb_rotate_kick_checker;
   localparam int BOARD_W = 10;
   localparam int BOARD_H = 20;
   localparam int ROW_AW  = 5;
`ifdef ROTATE_WALL_KICK_EN
   localparam int NKICK = 5;
`else
   localparam int NKICK = 1;
`endif

   logic               clk = 1'b0;
   logic               rst;
   logic [0:15]        rot_src;
   logic               rot_dir;
   logic [0:15]        rot_result;
   logic [ROW_AW-1:0]  row_addr;
   logic [0:BOARD_W-1] row_data;
   logic [0:BOARD_W-1] board [0:BOARD_H-1];

   int tests = 0;
   int fails = 0;

   rotate_kick_if rk_bus ();

   rotate_kick_checker #(.BOARD_W(BOARD_W), .BOARD_H(BOARD_H), .ROW_AW(ROW_AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (rk_bus),
      .rot_src    (rot_src),
      .rot_dir    (rot_dir),
      .rot_result (rot_result),
      .row_addr   (row_addr),
      .row_data   (row_data)
   );

   always #5 clk = ~clk;

   // 4x4 matrix rotation, cw: new(r,c)=old(3-c,r); ccw: new(r,c)=old(c,3-r)
   function automatic logic [0:15] rot4(input logic [0:15] m, input logic d);
      logic [0:15] o;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            o[4*r+c] = d ? m[4*c+3-r] : m[4*(3-c)+r];
      return o;
   endfunction

   assign rot_result = rot4(rot_src, rot_dir);

   // Board memory with one cycle read latency
   always @(posedge clk)
      row_data <= (int'(row_addr) < BOARD_H) ? board[row_addr] : '0;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic ref_model(input logic [0:15] fl, input logic d, input int px, input int py,
                            output logic eok, output logic [0:15] enf, output int enx, output int elat);
      int          offs [5];
      logic [0:15] rm;
      bit          hit;
      int          x;
      int          y;
      offs = '{0, 1, -1, 2, -2};
      rm   = rot4(fl, d);
      eok  = 1'b0;
      enf  = fl;
      enx  = px;
      elat = 7 + 5 * (NKICK - 1);
      for (int k = 0; k < NKICK; k++) begin
         hit = 1'b0;
         for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
               if (rm[4*r+c]) begin
                  x = px + offs[k] + c;
                  y = py + r;
                  if (x < 0 || x >= BOARD_W) hit = 1'b1;
                  else if (y >= BOARD_H) hit = 1'b1;
                  else if (y >= 0 && board[y][x]) hit = 1'b1;
               end
            end
         end
         if (!hit) begin
            eok  = 1'b1;
            enf  = rm;
            enx  = px + offs[k];
            elat = 7 + 5 * k;
            break;
         end
      end
   endtask

   task automatic fill_board(input bit full);
      for (int r = 0; r < BOARD_H; r++) board[r] = full ? '1 : '0;
   endtask

   // Issue one request and return the done cycle (-1 if none within budget)
   task automatic run_txn(input logic [0:15] fl, input logic d, input int px, input int py,
                          output int lat, output bit busy_ok);
      @(negedge clk);
      rk_bus.req       = 1'b1;
      rk_bus.float     = fl;
      rk_bus.direction = d;
      rk_bus.pos_x     = 5'(px);
      rk_bus.pos_y     = 6'(py);
      @(negedge clk);
      rk_bus.req = 1'b0;
      lat     = -1;
      busy_ok = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         if (rk_bus.done) begin
            lat = n;
            if (rk_bus.busy) busy_ok = 1'b0;
            break;
         end
         if (!rk_bus.busy) busy_ok = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic verify_txn(input string tag, input logic [0:15] fl, input logic d, input int px,
                             input int py, input logic eok, input logic [0:15] enf, input int enx,
                             input int elat);
      int lat;
      bit busy_ok;
      run_txn(fl, d, px, py, lat, busy_ok);
      check({tag, ".latency"}, lat, elat);
      check({tag, ".busy"}, busy_ok, 1);
      check({tag, ".ok"}, rk_bus.ok, eok);
      check({tag, ".new_float"}, rk_bus.new_float, enf);
      check({tag, ".new_x"}, int'(rk_bus.new_x), enx);
      check({tag, ".rot_src"}, {rot_dir, rot_src}, {d, fl});
      @(negedge clk);
      check({tag, ".hold"}, {rk_bus.done, rk_bus.ok}, {1'b0, eok});
   endtask

   typedef struct {
      string       name;
      logic [0:15] fl;
      logic        d;
      int          px;
      int          py;
      bit          full;
      logic        eok;
      logic [0:15] enf;
      int          enx;
      int          elat;
   } vec_t;

   vec_t vt [$];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat;
      int first_done;
      int ndone;
      logic eok;
      logic [0:15] enf;
      int enx;
      int elat;
      logic [0:15] fl;
      int px;
      int py;

      // Directed table: inputs and constant expectations
      vt.push_back(vec_t'{"t_spawn", 16'h4E00, 1'b0, 3, 0, 1'b0, 1'b1, 16'h2320, 3, 7});
      vt.push_back(vec_t'{"zero_mask", 16'h0000, 1'b0, -3, 19, 1'b1, 1'b1, 16'h0000, -3, 7});
      vt.push_back(vec_t'{"headroom", 16'h2222, 1'b1, 3, -2, 1'b1, 1'b1, 16'h0F00, 3, 7});
`ifdef ROTATE_WALL_KICK_EN
      vt.push_back(vec_t'{"left_wall", 16'h2222, 1'b0, -2, 5, 1'b0, 1'b1, 16'h00F0, 0, 22});
      vt.push_back(vec_t'{"full_board", 16'h4E00, 1'b0, 3, 8, 1'b1, 1'b0, 16'h4E00, 3, 27});
      vt.push_back(vec_t'{"floor", 16'h2222, 1'b0, 3, 18, 1'b0, 1'b0, 16'h2222, 3, 27});
      vt.push_back(vec_t'{"right_wall", 16'h2222, 1'b0, 8, 5, 1'b0, 1'b1, 16'h00F0, 6, 27});
      vt.push_back(vec_t'{"kick_one", 16'h2222, 1'b0, -1, 5, 1'b0, 1'b1, 16'h00F0, 0, 12});
      vt.push_back(vec_t'{"head_wall", 16'h2222, 1'b1, -3, -2, 1'b0, 1'b0, 16'h2222, -3, 27});
`else
      vt.push_back(vec_t'{"left_wall", 16'h2222, 1'b0, -2, 5, 1'b0, 1'b0, 16'h2222, -2, 7});
      vt.push_back(vec_t'{"full_board", 16'h4E00, 1'b0, 3, 8, 1'b1, 1'b0, 16'h4E00, 3, 7});
      vt.push_back(vec_t'{"floor", 16'h2222, 1'b0, 3, 18, 1'b0, 1'b0, 16'h2222, 3, 7});
      vt.push_back(vec_t'{"right_wall", 16'h2222, 1'b0, 8, 5, 1'b0, 1'b0, 16'h2222, 8, 7});
      vt.push_back(vec_t'{"kick_one", 16'h2222, 1'b0, -1, 5, 1'b0, 1'b0, 16'h2222, -1, 7});
      vt.push_back(vec_t'{"head_wall", 16'h2222, 1'b1, -3, -2, 1'b0, 1'b0, 16'h2222, -3, 7});
`endif

      rst              = 1'b1;
      rk_bus.req       = 1'b0;
      rk_bus.float     = '0;
      rk_bus.direction = 1'b0;
      rk_bus.pos_x     = '0;
      rk_bus.pos_y     = '0;
      fill_board(1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset.outputs",
            {rk_bus.busy, rk_bus.done, rk_bus.ok, rot_dir, rk_bus.new_float, rk_bus.new_x, rot_src, row_addr},
            0);
      rst = 1'b0;

      foreach (vt[i]) begin
         fill_board(vt[i].full);
         verify_txn(vt[i].name, vt[i].fl, vt[i].d, vt[i].px, vt[i].py,
                    vt[i].eok, vt[i].enf, vt[i].enx, vt[i].elat);
      end

      // Second request in cycle 3 must be ignored: one done, original result
      fill_board(1'b0);
      @(negedge clk);
      rk_bus.req = 1'b1; rk_bus.float = 16'h2222; rk_bus.direction = 1'b0;
      rk_bus.pos_x = -5'sd2; rk_bus.pos_y = 6'sd5;
      @(negedge clk);
      rk_bus.req = 1'b0;
      first_done = -1;
      ndone      = 0;
      for (int n = 1; n <= 45; n++) begin
         if (n == 3) begin
            rk_bus.req = 1'b1; rk_bus.float = 16'hFFFF; rk_bus.pos_x = 5'sd0;
         end
         if (n == 4) rk_bus.req = 1'b0;
         if (rk_bus.done) begin
            ndone++;
            if (first_done < 0) begin
               first_done = n;
               check("rereq.new_x", int'(rk_bus.new_x), (NKICK == 5) ? 0 : -2);
               check("rereq.ok", rk_bus.ok, (NKICK == 5) ? 1 : 0);
            end
         end
         @(negedge clk);
      end
      check("rereq.latency", first_done, (NKICK == 5) ? 22 : 7);
      check("rereq.done_count", ndone, 1);
      check("rereq.rot_src", rot_src, 16'h2222);

      // Reset in cycle 4 aborts with no done and clears all outputs from cycle 5
      fill_board(1'b1);
      @(negedge clk);
      rk_bus.req = 1'b1; rk_bus.float = 16'h4E00; rk_bus.direction = 1'b1;
      rk_bus.pos_x = 5'sd3; rk_bus.pos_y = 6'sd8;
      @(negedge clk);
      rk_bus.req = 1'b0;
      ndone = 0;
      for (int n = 1; n <= 40; n++) begin
         if (rk_bus.done) ndone++;
         if (n == 4) rst = 1'b1;
         if (n == 5) begin
            check("rst_mid.outputs",
                  {rk_bus.busy, rk_bus.done, rk_bus.ok, rot_dir, rk_bus.new_float, rk_bus.new_x, rot_src, row_addr},
                  0);
            rst = 1'b0;
         end
         @(negedge clk);
      end
      check("rst_mid.done_count", ndone, 0);

      // Randomized boards and masks against the reference model
      for (int t = 0; t < 40; t++) begin
         for (int r = 0; r < BOARD_H; r++)
            board[r] = (t % 4 == 0) ? '0 : (BOARD_W'($urandom) & BOARD_W'($urandom));
         fl = 16'($urandom) & 16'($urandom) & 16'($urandom);
         px = int'($urandom_range(12)) - 3;
         py = int'($urandom_range(23)) - 4;
         ref_model(fl, 1'($urandom), px, py, eok, enf, enx, elat);
         // direction bit is re-derived so model and stimulus agree
         begin
            logic d;
            d = 1'($urandom);
            ref_model(fl, d, px, py, eok, enf, enx, elat);
            verify_txn($sformatf("rnd%0d", t), fl, d, px, py, eok, enf, enx, elat);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
